// File: rtl/xswitch_dest_rx.sv
// xswitch_dest_rx: destination-side receive stage for one xswitch output port.
// Pulls packets from the switch core with single-cycle rd_en strobes and
// captures the address/data returned one cycle later into a small FIFO. The
// FIFO head is presented to the consumer over a valid/ready interface.
// Optional feature: define XSWITCH_RX_ADDR_CHECK_EN to drop packets whose
// address differs from MY_ADDR. Dropped packets are counted in err_cnt.
module xswitch_dest_rx #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 4,
  parameter logic [ADDR_W-1:0] MY_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       data_rdy,
  input  logic [ADDR_W-1:0]          addr_out,
  input  logic [DATA_W-1:0]          data_out,
  output logic                       rd_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                err_cnt
);

  localparam int PW = $clog2(DEPTH);

`ifdef XSWITCH_RX_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    CAPT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic [15:0]       pkt_cnt_q, err_cnt_q;

  logic empty, full, pop, capture, push, drop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // FIFO status from wrap-bit pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop is ignored while empty and while reset is asserted.
  assign pop = !reset && !empty && out_ready;

  assign head_addr = addr_mem[rd_ptr_q[PW-1:0]];
  assign head_data = data_mem[rd_ptr_q[PW-1:0]];

  // Misaddressed captures are discarded only when address checking is built in;
  // the slot reserved at rd_en simply goes unused.
  assign drop = ADDR_CHECK && capture && (addr_out != MY_ADDR);
  assign push = capture && !drop;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and strobe logic. No pending reservation can exist in IDLE, so
  // space means "not full", or full with a pop freeing a slot this cycle.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset && data_rdy && (!full || pop)) begin
          rd_en   = 1'b1;
          state_d = CAPT;
        end
      end
      CAPT: begin
        capture = !reset;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage: write-only array, no reset, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[PW-1:0]] <= addr_out;
      data_mem[wr_ptr_q[PW-1:0]] <= data_out;
    end
  end

  // Pointers, last-presented head value and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (drop && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + (PW+1)'(1);
        last_addr_q <= head_addr;
        last_data_q <= head_data;
      end
    end
  end

  // When empty the outputs keep showing the last entry handed to the consumer.
  assign out_valid = !empty;
  assign out_addr  = empty ? last_addr_q : head_addr;
  assign out_data  = empty ? last_data_q : head_data;
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = ADDR_CHECK ? err_cnt_q : 16'h0000;

endmodule

// File: tb/tb_xswitch_dest_rx.sv
// Testbench for xswitch_dest_rx. A queue-based model of the receive stage is
// stepped alongside the DUT one cycle at a time; inputs are driven on the
// falling edge and outputs sampled 1 ns later, well clear of the rising edge.
module tb_xswitch_dest_rx;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] TB_MY_ADDR = 8'h03;
`ifdef XSWITCH_RX_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [7:0] T2_ADDR = CHK ? TB_MY_ADDR : 8'h00;
  localparam int VW = 2 + OW + 8 + 8 + 16 + 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_rdy = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] addr_out = '0;
  logic [7:0] data_out = '0;
  logic rd_en, out_valid;
  logic [7:0] out_addr, out_data;
  logic [OW-1:0] occupancy;
  logic [15:0] pkt_cnt, err_cnt;

  xswitch_dest_rx #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (DEPTH),
    .MY_ADDR(TB_MY_ADDR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_rdy (data_rdy),
    .addr_out (addr_out),
    .data_out (data_out),
    .rd_en    (rd_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .occupancy(occupancy),
    .pkt_cnt  (pkt_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Switch-core side: packets waiting to be read, {addr, data}.
  logic [15:0] src_q[$];
  logic [15:0] cur_pkt = '0;
  // Model of the receive stage.
  logic [15:0] mq[$];
  logic [15:0] m_last = '0;
  bit          m_pending = 1'b0;
  logic [15:0] m_pkt = '0;
  logic [15:0] m_err = '0;

  logic [VW-1:0] obs_v, exp_v;
  logic          o_rd, o_valid;
  logic [OW-1:0] o_occ;
  logic [7:0]    o_data;
  logic [15:0]   o_pkt, o_err;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // One clock cycle: drive inputs, sample DUT, compute expectations, advance model.
  task automatic step(input bit rst, input bit rdy_gate, input bit rdy);
    bit valid_m, pop_m, rd_m;
    logic [15:0] head;
    reset     = rst;
    data_rdy  = rdy_gate && (src_q.size() != 0);
    out_ready = rdy;
    if (m_pending) begin
      addr_out = cur_pkt[15:8];
      data_out = cur_pkt[7:0];
    end else begin
      addr_out = 8'($urandom);
      data_out = 8'($urandom);
    end
    #1;
    o_rd = rd_en; o_valid = out_valid; o_occ = occupancy;
    o_data = out_data; o_pkt = pkt_cnt; o_err = err_cnt;
    obs_v = {rd_en, out_valid, occupancy, out_addr, out_data, pkt_cnt, err_cnt};
    valid_m = (mq.size() != 0);
    head    = valid_m ? mq[0] : m_last;
    pop_m   = !rst && valid_m && rdy;
    rd_m    = !rst && !m_pending && data_rdy && ((mq.size() - int'(pop_m)) < DEPTH);
    exp_v   = {rd_m, valid_m, OW'(mq.size()), head, m_pkt, m_err};
    if (rst) begin
      mq.delete();
      m_pending = 1'b0;
      m_pkt = '0; m_err = '0; m_last = '0;
    end else begin
      if (pop_m) m_last = mq.pop_front();
      if (m_pending) begin
        if (CHK && (cur_pkt[15:8] != TB_MY_ADDR)) begin
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end else begin
          mq.push_back(cur_pkt);
          if (m_pkt != 16'hFFFF) m_pkt = m_pkt + 16'd1;
        end
      end
      m_pending = rd_m;
      if (rd_m) cur_pkt = src_q.pop_front();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    src_q.delete();
    src_q.push_back({T2_ADDR, 8'hA5});
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_v !== '0) $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs_v);
      else n_pass++;
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_rd !== 1'b1) $display("FAIL first_rd_en cyc=%0d got=%b exp=1", cyc, o_rd);
    else n_pass++;
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_valid !== 1'b0 || obs_v !== exp_v)
      $display("FAIL single_capt cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hA5)
      $display("FAIL single_out cyc=%0d got valid=%b data=%h exp valid=1 data=a5", cyc, o_valid, o_data);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (o_occ !== '0 || o_pkt !== 16'd1 || obs_v !== exp_v)
      $display("FAIL single_done cyc=%0d got occ=%0d pkt=%0d exp occ=0 pkt=1", cyc, o_occ, o_pkt);
    else n_pass++;
  endtask

  task automatic test_fill();
    int cnt = 0;
    bit prev = 1'b0;
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back({TB_MY_ADDR, 8'($urandom)});
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL fill_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
      n_checks++;
      if (prev && o_rd) $display("FAIL rd_spacing cyc=%0d got=consecutive exp=gap", cyc);
      else n_pass++;
      if (o_rd === 1'b1) cnt++;
      prev = o_rd;
    end
    n_checks++;
    if (cnt != DEPTH || o_occ !== OW'(DEPTH))
      $display("FAIL fill_count cyc=%0d got rd=%0d occ=%0d exp rd=%0d occ=%0d", cyc, cnt, o_occ, DEPTH, DEPTH);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_rd !== 1'b1 || o_valid !== 1'b1 || obs_v !== exp_v)
      $display("FAIL full_pop_rd cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL full_pop_capt cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_occ !== OW'(DEPTH) || obs_v !== exp_v)
      $display("FAIL full_pop_occ cyc=%0d got occ=%0d exp occ=%0d", cyc, o_occ, DEPTH);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_capt();
    logic [7:0] d;
    src_q.delete();
    src_q.push_back({TB_MY_ADDR, 8'h5A});
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (o_occ !== '0 || o_pkt !== 16'd0 || o_valid !== 1'b0)
      $display("FAIL reset_capt_lost cyc=%0d got occ=%0d pkt=%0d valid=%b exp 0/0/0", cyc, o_occ, o_pkt, o_valid);
    else n_pass++;
    d = 8'($urandom);
    src_q.push_back({TB_MY_ADDR, d});
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== d || o_pkt !== 16'd1 || obs_v !== exp_v)
      $display("FAIL reset_capt_next cyc=%0d got valid=%b data=%h pkt=%0d exp 1/%h/1", cyc, o_valid, o_data, o_pkt, d);
    else n_pass++;
  endtask

  task automatic test_addr_check();
    int n_out = 0;
    step(1'b1, 1'b0, 1'b0);
    src_q.delete();
    src_q.push_back({8'h03, 8'h11});
    src_q.push_back({8'h05, 8'h22});
    src_q.push_back({8'h03, 8'h33});
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL addr_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
      if (o_valid === 1'b1) n_out++;
    end
    n_checks++;
    if (n_out != (CHK ? 2 : 3) || o_pkt !== (CHK ? 16'd2 : 16'd3) || o_err !== (CHK ? 16'd1 : 16'd0))
      $display("FAIL addr_counts cyc=%0d got out=%0d pkt=%0d err=%0d exp out=%0d pkt=%0d err=%0d",
               cyc, n_out, o_pkt, o_err, CHK ? 2 : 3, CHK ? 2 : 3, CHK ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 2)
        src_q.push_back({($urandom_range(0, 1) != 0) ? TB_MY_ADDR : 8'($urandom), 8'($urandom)});
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_reset_capt();
    test_addr_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
